scoreboard_regfile: RTL and testbench

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

---
 rtl/regfile_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 66 ++++++
 rtl/scoreboard_regfile.sv | 77 +++++++
 tb/tb_scoreboard_regfile.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and address type for the scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register (x0 never busy)
// plus a registered population count of the flags.
module reg_scoreboard import regfile_pkg::*; #(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_count
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             set_live_s;
  logic             clr_live_s;
  logic             set_rise_s;
  logic             clr_fall_s;

  // Next busy vector and count; the issue is applied after the clear so a same-cycle issue wins.
  always_comb begin
    set_live_s = set_en && (set_addr != {AW{1'b0}});
    clr_live_s = clr_en && (clr_addr != {AW{1'b0}});
    busy_nxt_s = busy_r;
    if (clr_live_s) begin
      busy_nxt_s[clr_addr] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (set_live_s) begin
      busy_nxt_s[set_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    // A flag rises only if it was clear; it falls only if set and not re-issued this cycle.
    set_rise_s = set_live_s && !busy_r[set_addr];
    clr_fall_s = clr_live_s && busy_r[clr_addr] &&
                 !(set_live_s && (set_addr == clr_addr));
    case ({set_rise_s, clr_fall_s})
      2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Busy flags and count registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r  <= {NREGS{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      busy_r  <= busy_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign busy       = busy_r;
  assign busy_count = count_r;

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-read-port register file with per-register pending-write scoreboard.
// x0 is hardwired to zero and is never busy.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the
// read ports; without it reads show stored state only.
module scoreboard_regfile import regfile_pkg::*; #(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NREAD = NREAD_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREAD-1:0][AW-1:0]    readAddr,
  output logic [NREAD-1:0][XLEN-1:0]  readData,
  output logic [NREAD-1:0]            readBusy,
  input  logic                        writeEnable,
  input  logic [AW-1:0]               writeAddr,
  input  logic [XLEN-1:0]             writeData,
  input  logic                        issueValid,
  input  logic [AW-1:0]               issueAddr,
  output logic [AW:0]                 busyCount
);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_s;
  logic             wr_live_s;

  assign wr_live_s = writeEnable && (writeAddr != {AW{1'b0}});

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (issueValid),
    .set_addr   (issueAddr),
    .clr_en     (writeEnable),
    .clr_addr   (writeAddr),
    .busy       (busy_s),
    .busy_count (busyCount)
  );

  // Register storage: cleared by reset, writes to x0 dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_live_s) begin
      regs_r[writeAddr] <= writeData;
    end
  end

  // Independent per-port read mux; x0 forced to zero, optional writeback forwarding.
  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      readData[p] = {XLEN{1'b0}};
      readBusy[p] = 1'b0;
      if (readAddr[p] == {AW{1'b0}}) begin
        readData[p] = {XLEN{1'b0}};
        readBusy[p] = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_live_s && !reset && (writeAddr == readAddr[p])) begin
        // The value arriving this cycle is already usable; only a fresh issue keeps it pending.
        readData[p] = writeData;
        readBusy[p] = issueValid && (issueAddr == readAddr[p]);
      end
`endif
      else begin
        readData[p] = regs_r[readAddr[p]];
        readBusy[p] = busy_s[readAddr[p]];
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Self-checking bench for scoreboard_regfile: directed scenarios plus random
// traffic against a behavioural array model (bypass-aware via REGFILE_BYPASS_EN).
module tb_scoreboard_regfile;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NREAD-1:0][AW-1:0]   readAddr;
  logic [NREAD-1:0][XLEN-1:0] readData;
  logic [NREAD-1:0]           readBusy;
  logic                       writeEnable;
  logic [AW-1:0]              writeAddr;
  logic [XLEN-1:0]            writeData;
  logic                       issueValid;
  logic [AW-1:0]              issueAddr;
  logic [AW:0]                busyCount;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk         (clk),
    .reset       (reset),
    .readAddr    (readAddr),
    .readData    (readData),
    .readBusy    (readBusy),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .issueValid  (issueValid),
    .issueAddr   (issueAddr),
    .busyCount   (busyCount)
  );

  always #5 clk = ~clk;

  function automatic void m_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [XLEN-1:0] m_data(input logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && writeEnable && writeAddr == a) return writeData;
`endif
    return m_regs[a];
  endfunction

  function automatic logic m_rbusy(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && writeEnable && writeAddr == a) return issueValid && (issueAddr == a);
`endif
    return m_busy[a];
  endfunction

  task automatic idle();
    writeEnable = 1'b0; writeAddr = '0; writeData = '0;
    issueValid  = 1'b0; issueAddr = '0;
  endtask

  // Advance one rising edge and apply the architectural effect of the held inputs.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_clear();
    end else begin
      if (writeEnable && writeAddr != '0) begin
        m_regs[writeAddr] = writeData;
        m_busy[writeAddr] = 1'b0;
      end
      if (issueValid && issueAddr != '0) m_busy[issueAddr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); readAddr = '0;
    repeat (2) tick();
    #2 reset = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      for (int p = 0; p < NREAD; p++) readAddr[p] = AW'(a);
      #1;
      for (int p = 0; p < NREAD; p++) begin
        n_tests++;
        if (readData[p] !== '0 || readBusy[p] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_read a=%0d p=%0d: got data=%0h busy=%0b expected 0/0", a, p, readData[p], readBusy[p]);
        end
      end
    end
    n_tests++;
    if (busyCount !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", busyCount);
    end
  endtask

  task automatic test_issue_writeback();
    issueValid = 1'b1; issueAddr = 5'd5;
    tick(); idle();
    readAddr[0] = 5'd5; readAddr[1] = 5'd5; #1;
    n_tests++;
    if (readBusy !== 2'b11 || busyCount !== 6'd1) begin
      n_fail++; $display("FAIL issue_x5: got busy=%b count=%0d expected 11/1", readBusy, busyCount);
    end
    writeEnable = 1'b1; writeAddr = 5'd5; writeData = 64'hDEADBEEF_00000001;
    tick(); idle(); #1;
    n_tests++;
    if (readBusy !== 2'b00 || busyCount !== 6'd0 || readData[0] !== 64'hDEADBEEF_00000001 ||
        readData[1] !== 64'hDEADBEEF_00000001) begin
      n_fail++; $display("FAIL writeback_x5: got busy=%b count=%0d data=%0h/%0h expected 00/0/deadbeef00000001",
                         readBusy, busyCount, readData[0], readData[1]);
    end
  endtask

  task automatic test_same_cycle();
    issueValid = 1'b1; issueAddr = 5'd7;
    tick(); idle();
    issueValid = 1'b1; issueAddr = 5'd7;
    writeEnable = 1'b1; writeAddr = 5'd7; writeData = 64'h55;
    tick(); idle();
    readAddr[0] = 5'd7; readAddr[1] = 5'd7; #1;
    n_tests++;
    if (readData[0] !== 64'h55 || readBusy[0] !== 1'b1 || busyCount !== 6'd1) begin
      n_fail++; $display("FAIL same_cycle_x7: got data=%0h busy=%b count=%0d expected 55/1/1",
                         readData[0], readBusy[0], busyCount);
    end
    writeEnable = 1'b1; writeAddr = 5'd7; writeData = 64'h56;
    tick(); idle(); #1;
    n_tests++;
    if (busyCount !== 6'd0 || readBusy[1] !== 1'b0) begin
      n_fail++; $display("FAIL clear_x7: got count=%0d busy=%b expected 0/0", busyCount, readBusy[1]);
    end
  endtask

  task automatic test_x0();
    writeEnable = 1'b1; writeAddr = '0; writeData = 64'hFFFF;
    issueValid  = 1'b1; issueAddr = '0;
    readAddr[0] = '0; readAddr[1] = '0; #1;
    n_tests++;
    if (readData[0] !== '0 || readBusy[0] !== 1'b0) begin
      n_fail++; $display("FAIL x0_same_cycle: got data=%0h busy=%b expected 0/0", readData[0], readBusy[0]);
    end
    tick(); idle(); #1;
    n_tests++;
    if (readData[1] !== '0 || readBusy !== 2'b00 || busyCount !== 6'd0) begin
      n_fail++; $display("FAIL x0_after: got data=%0h busy=%b count=%0d expected 0/00/0",
                         readData[1], readBusy, busyCount);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp_now;
    writeEnable = 1'b1; writeAddr = 5'd3; writeData = 64'hAAAA;
    tick(); idle();
    readAddr[0] = 5'd3; readAddr[1] = 5'd3;
    writeEnable = 1'b1; writeAddr = 5'd3; writeData = 64'h1234; #1;
`ifdef REGFILE_BYPASS_EN
    exp_now = 64'h1234;
`else
    exp_now = 64'hAAAA;
`endif
    n_tests++;
    if (readData[0] !== exp_now || readData[1] !== exp_now) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %0h/%0h expected %0h", readData[0], readData[1], exp_now);
    end
    tick(); idle(); #1;
    n_tests++;
    if (readData[0] !== 64'h1234) begin
      n_fail++; $display("FAIL bypass_next_cycle: got %0h expected 1234", readData[0]);
    end
    // Busy forwarding: pending x9 written this cycle, with and without a fresh issue.
    issueValid = 1'b1; issueAddr = 5'd9;
    tick(); idle();
    readAddr[0] = 5'd9; readAddr[1] = 5'd9;
    writeEnable = 1'b1; writeAddr = 5'd9; writeData = 64'h99; #1;
    n_tests++;
    if (readBusy[0] !== m_rbusy(5'd9) || readData[1] !== m_data(5'd9)) begin
      n_fail++; $display("FAIL bypass_busy_wb: got busy=%b data=%0h expected %b/%0h",
                         readBusy[0], readData[1], m_rbusy(5'd9), m_data(5'd9));
    end
    issueValid = 1'b1; issueAddr = 5'd9; #1;
    n_tests++;
    if (readBusy[1] !== 1'b1) begin
      n_fail++; $display("FAIL bypass_busy_reissue: got %b expected 1", readBusy[1]);
    end
    tick(); idle();
    writeEnable = 1'b1; writeAddr = 5'd9; writeData = 64'h9A;
    tick(); idle();
  endtask

  task automatic test_async_reset();
    for (int r = 1; r <= 3; r++) begin
      issueValid = 1'b1; issueAddr = AW'(r);
      tick();
    end
    idle();
    readAddr[0] = 5'd2; readAddr[1] = 5'd3; #1;
    n_tests++;
    if (busyCount !== 6'd3 || readBusy !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset: got count=%0d busy=%b expected 3/11", busyCount, readBusy);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (busyCount !== '0 || readBusy !== 2'b00 || readData[1] !== '0) begin
      n_fail++; $display("FAIL async_reset: got count=%0d busy=%b data3=%0h expected 0/00/0",
                         busyCount, readBusy, readData[1]);
    end
    m_clear();
    writeEnable = 1'b1; writeAddr = 5'd4; writeData = 64'h4444;
    issueValid  = 1'b1; issueAddr = 5'd4;
    tick(); idle();
    #2 reset = 1'b0;
    readAddr[0] = 5'd4; #1;
    n_tests++;
    if (readData[0] !== '0 || readBusy[0] !== 1'b0 || busyCount !== '0) begin
      n_fail++; $display("FAIL ignored_in_reset: got data=%0h busy=%b count=%0d expected 0/0/0",
                         readData[0], readBusy[0], busyCount);
    end
    writeEnable = 1'b1; writeAddr = 5'd2; writeData = 64'h77;
    tick(); idle();
    readAddr[1] = 5'd2; #1;
    n_tests++;
    if (busyCount !== '0 || readBusy[1] !== 1'b0 || readData[1] !== 64'h77) begin
      n_fail++; $display("FAIL wb_after_reset: got count=%0d busy=%b data=%0h expected 0/0/77",
                         busyCount, readBusy[1], readData[1]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      writeEnable = ($urandom_range(0, 99) < 55);
      writeAddr   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS-1));
      writeData   = {$urandom, $urandom};
      issueValid  = ($urandom_range(0, 99) < 50);
      issueAddr   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS-1));
      for (int p = 0; p < NREAD; p++)
        readAddr[p] = ($urandom_range(0, 3) == 0) ? writeAddr : AW'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < NREAD; p++) begin
        n_tests++;
        if (readData[p] !== m_data(readAddr[p]) || readBusy[p] !== m_rbusy(readAddr[p])) begin
          n_fail++; $display("FAIL rand_read it=%0d p=%0d a=%0d: got %0h/%b expected %0h/%b", it, p,
                             readAddr[p], readData[p], readBusy[p], m_data(readAddr[p]), m_rbusy(readAddr[p]));
        end
      end
      n_tests++;
      if (busyCount !== (AW+1)'(m_count())) begin
        n_fail++; $display("FAIL rand_count it=%0d: got %0d expected %0d", it, busyCount, m_count());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    m_clear();
    test_reset();
    test_issue_writeback();
    test_same_cycle();
    test_x0();
    test_bypass();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
